// File: rtl/prga_decrypt.sv
// RC4 PRGA + XOR decrypt stage: walks the scrambled S array, writes plaintext to dec memory.
// Optional PRGA_ASCII_CHECK_EN aborts on the first byte outside 'a'..'z' / space and flags key_bad.
module prga_decrypt #(
   parameter int unsigned MSG_LEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] s_q,
   output logic [7:0] s_addr,
   output logic [7:0] s_data,
   output logic       s_wr_en,
   output logic [7:0] enc_addr,
   input  logic [7:0] enc_q,
   output logic [7:0] dec_addr,
   output logic [7:0] dec_data,
   output logic       dec_wr_en,
   output logic       task_on,
   output logic       fin_strobe,
   output logic       key_bad
);

   typedef enum logic [3:0] {
      StIdle, StRdI, StLdI, StRdJ, StLdJ, StWrI, StWrJ, StRdF, StLdF, StWrD, StDone
   } state_e;

   localparam logic [7:0] LastK = 8'(MSG_LEN - 1);

   state_e     state_q, state_d;
   logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
   logic [7:0] si_q, si_d, sj_q, sj_d, ek_q, ek_d, f_q, f_d;
   logic [7:0] plain;
   logic       bad_char;

   assign plain = f_q ^ ek_q;

`ifdef PRGA_ASCII_CHECK_EN
   logic key_bad_q, key_bad_d;

   assign bad_char = !(((plain >= 8'h61) && (plain <= 8'h7a)) || (plain == 8'h20));
   assign key_bad  = key_bad_q;

   always_comb begin
      key_bad_d = key_bad_q;
      if ((state_q == StIdle) && start) key_bad_d = 1'b0;
      else if ((state_q == StWrD) && bad_char) key_bad_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) key_bad_q <= 1'b0;
      else     key_bad_q <= key_bad_d;
   end
`else
   assign bad_char = 1'b0;
   assign key_bad  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      si_d    = si_q;
      sj_d    = sj_q;
      ek_d    = ek_q;
      f_d     = f_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               i_d     = 8'd1;
               j_d     = 8'd0;
               k_d     = 8'd0;
               state_d = StRdI;
            end
         end
         StRdI: state_d = StLdI;
         StLdI: begin
            si_d    = s_q;
            ek_d    = enc_q;
            j_d     = j_q + s_q;
            state_d = StRdJ;
         end
         StRdJ: state_d = StLdJ;
         StLdJ: begin
            sj_d    = s_q;
            state_d = StWrI;
         end
         StWrI: state_d = StWrJ;
         StWrJ: state_d = StRdF;
         StRdF: state_d = StLdF;
         StLdF: begin
            f_d     = s_q;
            state_d = StWrD;
         end
         StWrD: begin
            if ((k_q == LastK) || bad_char) begin
               state_d = StDone;
            end else begin
               k_d     = k_q + 8'd1;
               i_d     = i_q + 8'd1;
               state_d = StRdI;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         k_q     <= 8'd0;
         si_q    <= 8'd0;
         sj_q    <= 8'd0;
         ek_q    <= 8'd0;
         f_q     <= 8'd0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         ek_q    <= ek_d;
         f_q     <= f_d;
      end
   end

   // Moore outputs: everything not driven by the current state stays at zero.
   always_comb begin
      s_addr     = 8'd0;
      s_data     = 8'd0;
      s_wr_en    = 1'b0;
      enc_addr   = 8'd0;
      dec_addr   = 8'd0;
      dec_data   = 8'd0;
      dec_wr_en  = 1'b0;
      fin_strobe = 1'b0;
      task_on    = (state_q != StIdle) && (state_q != StDone);
      unique case (state_q)
         StRdI: begin
            s_addr   = i_q;
            enc_addr = k_q;
         end
         StRdJ: s_addr = j_q;
         StWrI: begin
            s_addr  = i_q;
            s_data  = sj_q;
            s_wr_en = 1'b1;
         end
         StWrJ: begin
            s_addr  = j_q;
            s_data  = si_q;
            s_wr_en = 1'b1;
         end
         StRdF: s_addr = si_q + sj_q;
         StWrD: begin
            dec_addr  = k_q;
            dec_data  = plain;
            dec_wr_en = 1'b1;
         end
         StDone:  fin_strobe = 1'b1;
         default: ;
      endcase
   end

endmodule
